i2s_audio_out: RTL and testbench

- Standalone I2S transmitter for the board audio codec/amplifier.
- Sits directly downstream of the video/audio mixing stage and consumes its signed 16-bit left/right samples.
- Drives hp_bck / hp_ws / hp_din using a clock enable derived from clk. It never uses a generated clock net.
- Philips I2S framing: 32 BCK slots per frame, MSB first, WS leads data by one slot.

---
 rtl/i2s_pkg.sv | 41 ++++
 rtl/i2s_audio_out_if.sv | 22 ++
 rtl/i2s_bck_gen.sv | 46 ++++
 rtl/i2s_audio_out.sv | 97 +++++++++
 tb/tb_i2s_audio_out.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared constants, types and divider math for the I2S transmitter.
// Used by i2s_audio_out, i2s_bck_gen and the audio interface.
package i2s_pkg;

  localparam int unsigned DEF_CLK_HZ_PAL  = 31500000;
  localparam int unsigned DEF_CLK_HZ_NTSC = 32940000;
  localparam int unsigned DEF_SAMPLE_RATE = 24000;

  localparam int unsigned BITS   = 16;
  localparam int unsigned SLOT_W = 5;
  localparam int unsigned SLOTS  = 32;
  localparam int unsigned DIV_W  = 8;

  typedef logic signed [BITS-1:0] sample_t;
  typedef logic [SLOT_W-1:0]      slot_t;
  typedef logic [DIV_W-1:0]       div_t;
  typedef logic [2*BITS-1:0]      frame_t;

  localparam slot_t LAST_SLOT = slot_t'(SLOTS - 1);
  localparam slot_t CAP_SLOT  = slot_t'(SLOTS - 2);
  localparam slot_t WS_FIRST  = slot_t'(15);
  localparam slot_t WS_LAST   = slot_t'(30);

  function automatic div_t calc_half(
    input int unsigned clk_hz,
    input int unsigned rate
  );
    return div_t'(clk_hz / (rate * 2 * BITS) / 2);
  endfunction

  function automatic div_t half_of(
    input logic        ntsc,
    input int unsigned pal_hz  = DEF_CLK_HZ_PAL,
    input int unsigned ntsc_hz = DEF_CLK_HZ_NTSC,
    input int unsigned rate    = DEF_SAMPLE_RATE
  );
    return ntsc ? calc_half(ntsc_hz, rate)
                : calc_half(pal_hz, rate);
  endfunction

endpackage

// File: rtl/i2s_audio_out_if.sv
// Sample bus from the mixing stage into the I2S transmitter.
// master = upstream mixer, slave = transmitter.
interface i2s_audio_out_if;
  import i2s_pkg::*;

  sample_t audio_l;
  sample_t audio_r;
  logic    sample_strobe;

  modport master (
    output audio_l,
    output audio_r,
    input  sample_strobe
  );

  modport slave (
    input  audio_l,
    input  audio_r,
    output sample_strobe
  );

endinterface

// File: rtl/i2s_bck_gen.sv
// Clock-enable divider: registered I2S bit clock plus a one-cycle
// pulse marking the clk edge on which hp_bck falls.
module i2s_bck_gen
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_HZ_PAL  = DEF_CLK_HZ_PAL,
  parameter int unsigned CLK_HZ_NTSC = DEF_CLK_HZ_NTSC,
  parameter int unsigned SAMPLE_RATE = DEF_SAMPLE_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ntscmode,
  output logic hp_bck,
  output logic fall_evt
);

  localparam div_t HALF_PAL =
    half_of(1'b0, CLK_HZ_PAL, CLK_HZ_NTSC, SAMPLE_RATE);
  localparam div_t HALF_NTSC =
    half_of(1'b1, CLK_HZ_PAL, CLK_HZ_NTSC, SAMPLE_RATE);
  localparam div_t TERM_PAL  = HALF_PAL - div_t'(1);
  localparam div_t TERM_NTSC = HALF_NTSC - div_t'(1);

  div_t div_cnt;
  div_t term;
  logic wrap;

  assign term = ntscmode ? TERM_NTSC : TERM_PAL;

  // >= so a switch to a shorter terminal wraps on the next edge
  assign wrap     = div_cnt >= term;
  assign fall_evt = wrap & hp_bck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      hp_bck  <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      hp_bck  <= ~hp_bck;
    end else begin
      div_cnt <= div_cnt + div_t'(1);
    end
  end

endmodule

// File: rtl/i2s_audio_out.sv
// Philips I2S transmitter, 32 slots/frame, MSB first, WS one slot early.
// Define I2S_MONO_MIX_EN to send the L/R average on both channels.
module i2s_audio_out
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_HZ_PAL  = DEF_CLK_HZ_PAL,
  parameter int unsigned CLK_HZ_NTSC = DEF_CLK_HZ_NTSC,
  parameter int unsigned SAMPLE_RATE = DEF_SAMPLE_RATE
) (
  input  logic            clk,
  input  logic            pll_lock,
  input  logic            ntscmode,
  i2s_audio_out_if.slave  aud,
  output logic            hp_bck,
  output logic            hp_ws,
  output logic            hp_din
);

  logic    fall_evt;
  logic    capture;
  logic    load;
  logic    ws_nxt;
  slot_t   slot;
  slot_t   slot_nxt;
  sample_t cap_l;
  sample_t cap_r;
  sample_t hold_l;
  sample_t hold_r;
  frame_t  frame;

  i2s_bck_gen #(
    .CLK_HZ_PAL  (CLK_HZ_PAL),
    .CLK_HZ_NTSC (CLK_HZ_NTSC),
    .SAMPLE_RATE (SAMPLE_RATE)
  ) u_bck (
    .clk      (clk),
    .rst_n    (pll_lock),
    .ntscmode (ntscmode),
    .hp_bck   (hp_bck),
    .fall_evt (fall_evt)
  );

  assign slot_nxt = slot + slot_t'(1);
  assign capture  = fall_evt && (slot == CAP_SLOT);
  assign load     = fall_evt && (slot == LAST_SLOT);
  assign ws_nxt   = (slot_nxt >= WS_FIRST) &&
                    (slot_nxt <= WS_LAST);

  assign aud.sample_strobe = capture;

`ifdef I2S_MONO_MIX_EN
  logic [BITS:0] mix_sum;

  assign mix_sum = {aud.audio_l[BITS-1], aud.audio_l} +
                   {aud.audio_r[BITS-1], aud.audio_r};
  assign cap_l   = sample_t'(mix_sum >> 1);
  assign cap_r   = cap_l;
`else
  assign cap_l = aud.audio_l;
  assign cap_r = aud.audio_r;
`endif

  always_ff @(posedge clk or negedge pll_lock) begin
    if (!pll_lock) begin
      hold_l <= '0;
      hold_r <= '0;
    end else if (capture) begin
      hold_l <= cap_l;
      hold_r <= cap_r;
    end
  end

  always_ff @(posedge clk or negedge pll_lock) begin
    if (!pll_lock) begin
      slot  <= LAST_SLOT;
      hp_ws <= 1'b0;
    end else if (fall_evt) begin
      slot  <= slot_nxt;
      hp_ws <= ws_nxt;
    end
  end

  // MSB goes straight out on load; the rest shifts up behind it
  always_ff @(posedge clk or negedge pll_lock) begin
    if (!pll_lock) begin
      frame  <= '0;
      hp_din <= 1'b0;
    end else if (load) begin
      frame  <= {hold_l, hold_r} << 1;
      hp_din <= hold_l[BITS-1];
    end else if (fall_evt) begin
      frame  <= frame << 1;
      hp_din <= frame[2*BITS-1];
    end
  end

endmodule

// File: tb/tb_i2s_audio_out.sv
// Scoreboard bench for i2s_audio_out: expected frames are queued at each
// capture and compared slot by slot as the serial stream comes out.
module tb_i2s_audio_out;
  import i2s_pkg::*;

  logic clk = 1'b0;
  logic pll_lock;
  logic ntscmode;
  logic hp_bck;
  logic hp_ws;
  logic hp_din;
  logic [15:0] drv_l;
  logic [15:0] drv_r;

  i2s_audio_out_if aud();

  assign aud.audio_l = drv_l;
  assign aud.audio_r = drv_r;

  i2s_audio_out dut (
    .clk      (clk),
    .pll_lock (pll_lock),
    .ntscmode (ntscmode),
    .aud      (aud),
    .hp_bck   (hp_bck),
    .hp_ws    (hp_ws),
    .hp_din   (hp_din)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_g = 0;
  int rel_cyc = 0;
  int chg_cyc = -1;
  int mon_slot = 31;
  int last_fall = -1;
  int last_strobe = -1;
  int last_act = 0;
  bit prev_bck = 1'b0;
  bit await_rise = 1'b1;
  bit await_fall = 1'b1;
  bit load_next = 1'b0;
  logic [31:0] cur_word = '0;
  logic [31:0] exp_q[$];
  logic [15:0] vec_l[$];
  logic [15:0] vec_r[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, exp, cyc_g);
    end
  endtask

  task automatic check_le(input string name,
                          input int act,
                          input int lim);
    checks++;
    if (act > lim) begin
      failures++;
      $display("FAIL %s: got %0d expected at most %0d at cycle %0d",
               name, act, lim, cyc_g);
    end
  endtask

  // BCK half period in clk cycles, by video standard
  function automatic int half_exp(input logic n);
    return n ? 21 : 20;
  endfunction

  function automatic logic [31:0] model_word(input logic [15:0] l,
                                             input logic [15:0] r);
`ifdef I2S_MONO_MIX_EN
    int s;
    logic [15:0] m;
    s = int'($signed(l)) + int'($signed(r));
    s = s >>> 1;
    m = s[15:0];
    return {m, m};
`else
    return {l, r};
`endif
  endfunction

  // driver: queue the expected frame at each capture, then move on
  always @(negedge clk) begin
    if (pll_lock && aud.sample_strobe) begin
      exp_q.push_back(model_word(drv_l, drv_r));
      load_next = 1'b1;
    end else if (load_next) begin
      load_next = 1'b0;
      if (vec_l.size() > 0) begin
        drv_l = vec_l.pop_front();
        drv_r = vec_r.pop_front();
      end else begin
        drv_l = 16'($urandom);
        drv_r = 16'($urandom);
      end
    end
  end

  // monitor: timing plus per-slot ws/din against the queued frame
  always @(negedge clk) begin
    cyc_g++;
    if (!pll_lock) begin
      rel_cyc = 0;
      prev_bck = 1'b0;
      mon_slot = 31;
      await_rise = 1'b1;
      await_fall = 1'b1;
      last_fall = -1;
      last_strobe = -1;
      last_act = cyc_g;
    end else begin
      rel_cyc++;
      if (hp_bck != prev_bck) last_act = cyc_g;
      if (hp_bck && !prev_bck && await_rise) begin
        check("first_rise", rel_cyc, half_exp(ntscmode));
        await_rise = 1'b0;
      end
      if (!hp_bck && prev_bck) begin
        if (await_fall) begin
          check("first_fall", rel_cyc, 2 * half_exp(ntscmode));
          await_fall = 1'b0;
        end
        if (last_fall >= 0 && last_fall > chg_cyc)
          check("bck_period", cyc_g - last_fall, 2 * half_exp(ntscmode));
        else if (last_fall >= 0)
          check_le("bck_period_bound", cyc_g - last_fall, 44);
        last_fall = cyc_g;
        mon_slot = (mon_slot + 1) % 32;
        if (mon_slot == 0) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame_queue: got empty expected a frame at cycle %0d",
                     cyc_g);
            cur_word = '0;
          end else begin
            cur_word = exp_q.pop_front();
          end
        end
        check("ws", hp_ws, (mon_slot >= 15 && mon_slot <= 30));
        check("din", hp_din, cur_word[31 - mon_slot]);
      end
      if (aud.sample_strobe) begin
        check("strobe_slot", mon_slot, 30);
        if (last_strobe >= 0 && last_strobe > chg_cyc)
          check("frame_period", cyc_g - last_strobe, 64 * half_exp(ntscmode));
        last_strobe = cyc_g;
      end
      if (cyc_g - last_act > 200) begin
        checks++;
        failures++;
        $display("FAIL bck_stall: got %0d idle cycles expected at most 200",
                 cyc_g - last_act);
        last_act = cyc_g;
      end
      prev_bck = hp_bck;
    end
  end

  initial begin
    bit found;
    pll_lock = 1'b0;
    ntscmode = 1'b0;
    drv_l = 16'h8001;
    drv_r = 16'h7FFE;
    vec_l = '{16'h4000, 16'h8000, 16'h0000, 16'h7FFF, 16'h8001};
    vec_r = '{16'h2000, 16'h8000, 16'hFFFF, 16'h8000, 16'h7FFE};
    exp_q.push_back(32'h0);

    repeat (3) @(negedge clk);
    check("rst_bck", hp_bck, 0);
    check("rst_ws", hp_ws, 0);
    check("rst_din", hp_din, 0);
    check("rst_strobe", aud.sample_strobe, 0);
    #1 pll_lock = 1'b1;

    repeat (5 * 1280) @(negedge clk);
    #1 ntscmode = 1'b1;
    chg_cyc = cyc_g;
    repeat (3 * 1344) @(negedge clk);

    // leave NTSC while the count sits above the PAL terminal
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (dut.u_bck.div_cnt == 8'd20) found = 1'b1;
    end
    check("find_div20", found, 1);
    #1 ntscmode = 1'b0;
    chg_cyc = cyc_g;
    @(negedge clk);
    check("switch_wrap", dut.u_bck.div_cnt, 0);

    repeat (3 * 1280) @(negedge clk);
    repeat ($urandom_range(1, 40)) @(negedge clk);
    #1 ntscmode = 1'b1;
    chg_cyc = cyc_g;
    repeat (2 * 1344 + $urandom_range(1, 40)) @(negedge clk);
    #1 ntscmode = 1'b0;
    chg_cyc = cyc_g;
    repeat (2 * 1280) @(negedge clk);

    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      #1;
      if (mon_slot == 9) found = 1'b1;
    end
    check("find_slot9", found, 1);
    #1 pll_lock = 1'b0;
    #1;
    check("async_bck", hp_bck, 0);
    check("async_ws", hp_ws, 0);
    check("async_din", hp_din, 0);
    check("async_strobe", aud.sample_strobe, 0);
    exp_q.delete();
    exp_q.push_back(32'h0);
    repeat (3) @(negedge clk);
    #1 pll_lock = 1'b1;

    repeat (3 * 1280 + 100) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
